// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and counter-width helper for the button conditioner
package btn_pkg;
    typedef enum logic [2:0] {IDLE, DB_PRESS, HELD_WAIT, HELD_RPT, DB_REL} state_t;
    // Width large enough that no counter can wrap before its compare value.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button -- 2-flop sync, debounce, press/release pulses, auto-repeat
//   clk       system clock
//   reset     synchronous reset, active-low
//   raw       asynchronous raw level, 1 = pressed
//   repeat_en auto-repeat enable (sampled every cycle)
//   dpb       debounced level
//   scen      one-cycle pulse on accepted press
//   rpt       one-cycle pulse on accepted press and every repeat tick
//   rel       one-cycle pulse on accepted release
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 8000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic repeat_en,
    output logic dpb,
    output logic scen,
    output logic rpt,
    output logic rel
);
    localparam int CNT_W = cnt_w(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DB_C = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] RD_C = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_C = CNT_W'(REPEAT_RATE - 1);
    logic s1, s;
    state_t state, state_nxt;
    logic [CNT_W-1:0] dcnt, dcnt_nxt, dcnt_inc, rcnt, rcnt_nxt;
    logic dpb_nxt, scen_nxt, rpt_nxt, rel_nxt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            state <= IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
            dpb   <= 1'b0;
            scen  <= 1'b0;
            rpt   <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= raw;
            s     <= s1;
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            rcnt  <= rcnt_nxt;
            dpb   <= dpb_nxt;
            scen  <= scen_nxt;
            rpt   <= rpt_nxt;
            rel   <= rel_nxt;
        end
    end
    // dcnt is kept at 0 in IDLE and the held states, so dcnt+1 is the
    // number of consecutive samples at the new level including this one.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        rcnt_nxt  = rcnt;
        dpb_nxt   = dpb;
        scen_nxt  = 1'b0;
        rpt_nxt   = 1'b0;
        rel_nxt   = 1'b0;
        dcnt_inc  = dcnt + CNT_W'(1);
        case (state)
            IDLE, DB_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else if (dcnt_inc == DB_C) begin
                    state_nxt = HELD_WAIT;
                    dcnt_nxt  = '0;
                    rcnt_nxt  = '0;
                    dpb_nxt   = 1'b1;
                    scen_nxt  = 1'b1;
                    rpt_nxt   = 1'b1;
                end else begin
                    state_nxt = DB_PRESS;
                    dcnt_nxt  = dcnt_inc;
                end
            end
            HELD_WAIT, HELD_RPT, DB_REL: begin
                if (!s) begin
                    rcnt_nxt = '0;
                    if (dcnt_inc == DB_C) begin
                        state_nxt = IDLE;
                        dcnt_nxt  = '0;
                        dpb_nxt   = 1'b0;
                        rel_nxt   = 1'b1;
                    end else begin
                        state_nxt = DB_REL;
                        dcnt_nxt  = dcnt_inc;
                    end
                end else if (state == DB_REL) begin
                    // Release bounce: back to held, repeat timing restarts.
                    state_nxt = HELD_WAIT;
                    dcnt_nxt  = '0;
                    rcnt_nxt  = '0;
                end else if (!repeat_en) begin
                    state_nxt = HELD_WAIT;
                    rcnt_nxt  = '0;
                end else if (rcnt == ((state == HELD_WAIT) ? RD_C : RR_C)) begin
                    state_nxt = HELD_RPT;
                    rcnt_nxt  = '0;
                    rpt_nxt   = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
                rcnt_nxt  = '0;
            end
        endcase
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_CH independent push-button conditioners
//   Clk       system clock
//   Reset     synchronous reset, active-low
//   Btn_raw   raw button levels, 1 = pressed
//   Repeat_en per-channel auto-repeat enable
//   Dpb       debounced levels
//   Scen      press pulses
//   Rpt       press + auto-repeat pulses
//   Rel       release pulses
module btn_conditioner #(
    parameter int N_CH         = 5,
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 8000000
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] Btn_raw,
    input  logic [N_CH-1:0] Repeat_en,
    output logic [N_CH-1:0] Dpb,
    output logic [N_CH-1:0] Scen,
    output logic [N_CH-1:0] Rpt,
    output logic [N_CH-1:0] Rel
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk      (Clk),
            .reset    (Reset),
            .raw      (Btn_raw[i]),
            .repeat_en(Repeat_en[i]),
            .dpb      (Dpb[i]),
            .scen     (Scen[i]),
            .rpt      (Rpt[i]),
            .rel      (Rel[i])
        );
    end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised multi-channel push-button conditioner. It replaces the per-button debouncer instances that feed the game logic (block_gen move and rotate inputs).
- Each channel does the following:
  - 2-flop synchronisation of the raw pad signal.
  - Counter-based debounce.
  - Single-cycle press and release pulses.
  - Optional auto-repeat with an initial delay followed by a fixed repeat rate, so a held Left, Right or Down key repeats.
- Sits between board pads and game-clock logic; all outputs are synchronous to Clk.

Parameters:
- N_CH, 5, number of independent button channels.
- DB_CYCLES, 1000000, consecutive equal synchronised samples required to accept a level change (>=1).
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first repeat pulse (>=2).
- REPEAT_RATE, 8000000, cycles between subsequent repeat pulses (>=2).
- CNT_W, derived localparam, equal to $clog2(max(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-low.
- Btn_raw  in  N_CH  asynchronous raw button levels; 1 = pressed.
- Repeat_en  in  N_CH  per-channel auto-repeat enable, sampled every cycle.
- Dpb  out  N_CH  debounced level.
- Scen  out  N_CH  one-cycle pulse on accepted press.
- Rpt  out  N_CH  one-cycle pulse on accepted press and on every auto-repeat tick.
- Rel  out  N_CH  one-cycle pulse on accepted release.

Behaviour:
- Interface (already decided): one clock, Clk; reset is synchronous, active-low, on port Reset.
- Reset=0 at a Clk edge:
  - Sync flops, counters, Dpb, Scen, Rpt and Rel are cleared to 0.
  - Every channel's FSM returns to IDLE.
  - Reset takes priority over all other inputs. Asserting it mid-debounce or mid-repeat discards that progress with no pulses.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Sync stage: s = Btn_raw delayed by 2 flops.
- Per-channel FSM states and transitions:
  - IDLE:
    - s=1 moves to DB_PRESS with dcnt=1.
  - DB_PRESS:
    - s=0 returns to IDLE with dcnt=0 and no pulse.
    - Otherwise dcnt increments.
    - On the sample where dcnt reaches DB_CYCLES: go to HELD_WAIT, register Dpb=1, and pulse Scen and Rpt for the next cycle. rcnt=0.
  - HELD_WAIT:
    - s=0 moves to DB_REL with dcnt=1 and rcnt=0.
    - Else if Repeat_en=0, rcnt is held at 0.
    - Else rcnt increments. At rcnt = REPEAT_DELAY-1, pulse Rpt, clear rcnt and go to HELD_RPT.
  - HELD_RPT:
    - s=0 moves to DB_REL.
    - Repeat_en=0 moves to HELD_WAIT with rcnt=0.
    - Else rcnt increments. At rcnt = REPEAT_RATE-1, pulse Rpt and clear rcnt.
  - DB_REL:
    - s=1 returns to HELD_WAIT with rcnt=0. The repeat timing restarts and there is no pulse.
    - Otherwise dcnt increments.
    - At dcnt = DB_CYCLES: go to IDLE, register Dpb=0, pulse Rel.
- Press-pulse latency:
  - Raw held stable high from the first sampling edge E gives Scen/Rpt high in the cycle following edge E+DB_CYCLES+1, i.e. 2 sync edges plus DB_CYCLES samples.
  - Dpb rises in the same cycle as Scen.
- Repeat timing:
  - First repeat Rpt occurs exactly REPEAT_DELAY cycles after the Scen cycle.
  - Subsequent repeats occur every REPEAT_RATE cycles.
- Release latency: same as press. Rel rises in the same cycle that Dpb falls.
- Pulse rules:
  - Every pulse is exactly 1 cycle wide. Outputs are registered with no combinational path from inputs.
  - Scen and Rel never assert in the same cycle on one channel.
- Counters saturate-free: every compare uses the full CNT_W width. Widths are chosen so the counters never wrap.
- If a button is held through reset deassertion, it is treated as a new press: it is debounced and Scen fires.

Decomposition:
- Package btn_pkg holds:
  - The FSM state enum: IDLE, DB_PRESS, HELD_WAIT, HELD_RPT, DB_REL, in 3 bits.
  - The function computing CNT_W.
- Sub-module btn_channel:
  - Contains the single-channel sync, FSM and counters.
  - Takes the same parameters.
  - btn_conditioner is a generate loop of N_CH instances.

Test Plan (N_CH=5, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3):
- Reset: hold Reset=0 for 3 cycles with Btn_raw=5'b11111 -> all outputs 0. Release Reset -> Scen=5'b11111 exactly 6 edges later, then 0 on the next cycle.
- Glitch reject: ch0 high for 3 edges then low -> no Dpb, Scen, Rpt or Rel ever. Then ch0 high for 4 edges -> Dpb[0]=1 with a single Scen[0] pulse.
- Auto-repeat: ch1 held 40 cycles with Repeat_en[1]=1 -> Rpt[1] pulses at Scen cycle +0, +10, +13, +16, ... Release -> Rel[1] pulse 6 cycles after the raw fall, with no further Rpt.
- Repeat gating: ch2 held with Repeat_en[2]=0 -> only the press Rpt. Raising Repeat_en mid-hold -> first repeat 10 cycles after the enable edge.
- Release bounce: during DB_REL, ch3 raw goes high for 1 cycle -> no Rel. Rpt timing restarts at 10 cycles.
- Simultaneous events: ch0 press and ch4 release complete in the same cycle -> Scen=5'b00001 and Rel=5'b10000 in that cycle. Reset=0 asserted mid-repeat -> outputs 0 on the next cycle.
